// File: rtl/tpu_matrix_buffer_pkg.sv
// Shared constants, bank-select codes and FSM state type for the TPU matrix buffer.
package tpu_buf_pkg;

  localparam int BUF_DEPTH = 64;
  localparam int BUF_AW    = $clog2(BUF_DEPTH);
  localparam int BUF_DW    = 16;
  localparam int BUF_CW    = 8;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_RES  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  function automatic logic even_par(input logic [BUF_DW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tpu_matrix_buffer_if.sv
// Host and compute-side signal bundle of tpu_matrix_buffer; slave = buffer, master = driver.
interface tpu_matrix_buffer_if;
  import tpu_buf_pkg::*;

  logic [7:0]        host_addr;
  logic [BUF_DW-1:0] host_wdata;
  logic              host_we;
  logic [1:0]        host_sel;
  logic [BUF_DW-1:0] host_rdata;
  logic              compute_active;
  logic              clear_req;
  logic [BUF_AW-1:0] cmp_a_addr;
  logic [BUF_AW-1:0] cmp_b_addr;
  logic              cmp_rd_en;
  logic [BUF_DW-1:0] cmp_a_rdata;
  logic [BUF_DW-1:0] cmp_b_rdata;
  logic              cmp_rd_valid;
  logic              cmp_res_we;
  logic [BUF_AW-1:0] cmp_res_addr;
  logic [BUF_DW-1:0] cmp_res_wdata;
  logic              clear_busy;
  logic              host_wr_blocked;
  logic [BUF_CW-1:0] blocked_cnt;
  logic              par_err;

  modport slave (
    input  host_addr, host_wdata, host_we, host_sel, compute_active, clear_req,
           cmp_a_addr, cmp_b_addr, cmp_rd_en, cmp_res_we, cmp_res_addr, cmp_res_wdata,
    output host_rdata, cmp_a_rdata, cmp_b_rdata, cmp_rd_valid, clear_busy,
           host_wr_blocked, blocked_cnt, par_err
  );

  modport master (
    output host_addr, host_wdata, host_we, host_sel, compute_active, clear_req,
           cmp_a_addr, cmp_b_addr, cmp_rd_en, cmp_res_we, cmp_res_addr, cmp_res_wdata,
    input  host_rdata, cmp_a_rdata, cmp_b_rdata, cmp_rd_valid, clear_busy,
           host_wr_blocked, blocked_cnt, par_err
  );

endinterface

// File: rtl/tpu_buf_bank.sv
// One LUTRAM bank: sync write, async host read, registered compute read.
// Optional even-parity storage/check enabled by `MEM_PARITY_EN.
module tpu_buf_bank
  import tpu_buf_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int WIDTH = BUF_DW,
  parameter int AW    = BUF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    haddr,
  output logic [WIDTH-1:0] hrdata,
  input  logic             rd_en,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             par_bad
);

`ifdef MEM_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] store_word;
  logic [SW-1:0] rd_word;

`ifdef MEM_PARITY_EN
  // Zero data has zero parity, so clear writes need no special case.
  assign store_word = {even_par(wdata), wdata};
  assign par_bad    = rd_en & (^rd_word);
`else
  assign store_word = wdata;
  assign par_bad    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= store_word;
  end

  assign hrdata  = mem[haddr][WIDTH-1:0];
  assign rd_word = mem[raddr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= rd_word[WIDTH-1:0];
  end

endmodule

// File: rtl/tpu_matrix_buffer.sv
// A/B/result triple-bank store with host/compute write arbitration, operand lock,
// zero-fill sequencer and blocked-write counter. Optional parity: `MEM_PARITY_EN.
module tpu_matrix_buffer
  import tpu_buf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  tpu_matrix_buffer_if.slave   bus
);

  state_t            state, state_nxt;
  logic [BUF_AW-1:0] clr_ptr, clr_ptr_nxt;
  logic              clearing, clr_done;

  logic [BUF_AW-1:0] haddr;
  logic [1:0]        addr_hi_unused;
  logic              host_wr, blocked, host_ok;

  logic              we_a, we_b, we_r;
  logic [BUF_AW-1:0] waddr_ab, waddr_r;
  logic [BUF_DW-1:0] wdata_ab, wdata_r;
  logic [BUF_DW-1:0] a_h, b_h, r_h;
  logic [BUF_DW-1:0] a_rd, b_rd, res_rd_unused;
  logic              a_bad, b_bad, r_bad_unused;

  logic              rd_valid, wr_blocked;
  logic [BUF_CW-1:0] blk_cnt;

  assign haddr          = bus.host_addr[BUF_AW-1:0];
  assign addr_hi_unused = bus.host_addr[7:6];
  assign clearing       = (state == ST_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    clr_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.clear_req) begin
          state_nxt   = ST_CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      ST_CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == BUF_AW'(BUF_DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          clr_done  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Compute result writes take priority over host writes to the result bank.
  always_comb begin
    host_wr = bus.host_we && (bus.host_sel != SEL_NONE);
    blocked = host_wr && (clearing
                          || (bus.compute_active && (bus.host_sel == SEL_A || bus.host_sel == SEL_B))
                          || (bus.host_sel == SEL_RES && bus.cmp_res_we));
    host_ok = host_wr && !blocked;

    we_a     = clearing || (host_ok && bus.host_sel == SEL_A);
    we_b     = clearing || (host_ok && bus.host_sel == SEL_B);
    waddr_ab = clearing ? clr_ptr : haddr;
    wdata_ab = clearing ? '0 : bus.host_wdata;

    we_r    = clearing || bus.cmp_res_we || (host_ok && bus.host_sel == SEL_RES);
    waddr_r = clearing ? clr_ptr : (bus.cmp_res_we ? bus.cmp_res_addr : haddr);
    wdata_r = clearing ? '0 : (bus.cmp_res_we ? bus.cmp_res_wdata : bus.host_wdata);
  end

  tpu_buf_bank #(.DEPTH(BUF_DEPTH), .WIDTH(BUF_DW), .AW(BUF_AW)) u_bank_a (
    .clk(clk), .rst(rst), .we(we_a), .waddr(waddr_ab), .wdata(wdata_ab),
    .haddr(haddr), .hrdata(a_h), .rd_en(bus.cmp_rd_en), .raddr(bus.cmp_a_addr),
    .rdata(a_rd), .par_bad(a_bad)
  );

  tpu_buf_bank #(.DEPTH(BUF_DEPTH), .WIDTH(BUF_DW), .AW(BUF_AW)) u_bank_b (
    .clk(clk), .rst(rst), .we(we_b), .waddr(waddr_ab), .wdata(wdata_ab),
    .haddr(haddr), .hrdata(b_h), .rd_en(bus.cmp_rd_en), .raddr(bus.cmp_b_addr),
    .rdata(b_rd), .par_bad(b_bad)
  );

  tpu_buf_bank #(.DEPTH(BUF_DEPTH), .WIDTH(BUF_DW), .AW(BUF_AW)) u_bank_r (
    .clk(clk), .rst(rst), .we(we_r), .waddr(waddr_r), .wdata(wdata_r),
    .haddr(haddr), .hrdata(r_h), .rd_en(1'b0), .raddr('0),
    .rdata(res_rd_unused), .par_bad(r_bad_unused)
  );

  always_comb begin
    case (bus.host_sel)
      SEL_A:   bus.host_rdata = a_h;
      SEL_B:   bus.host_rdata = b_h;
      SEL_RES: bus.host_rdata = r_h;
      default: bus.host_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid   <= 1'b0;
      wr_blocked <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      rd_valid   <= bus.cmp_rd_en;
      wr_blocked <= blocked;
      if (clr_done)                      blk_cnt <= '0;
      else if (blocked && blk_cnt != '1) blk_cnt <= blk_cnt + 1'b1;
    end
  end

  assign bus.cmp_a_rdata     = a_rd;
  assign bus.cmp_b_rdata     = b_rd;
  assign bus.cmp_rd_valid    = rd_valid;
  assign bus.host_wr_blocked = wr_blocked;
  assign bus.blocked_cnt     = blk_cnt;
  assign bus.clear_busy      = clearing;

`ifdef MEM_PARITY_EN
  logic par_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 par_err_q <= 1'b0;
    else if (clr_done)       par_err_q <= 1'b0;
    else if (a_bad || b_bad) par_err_q <= 1'b1;
  end
  assign bus.par_err = par_err_q;
`else
  logic par_unused;
  assign par_unused  = a_bad | b_bad;
  assign bus.par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_matrix_buffer.sv
// Self-checking bench for tpu_matrix_buffer: directed sequences, blocking-rule table, random traffic.
module tb_tpu_matrix_buffer;
  import tpu_buf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tpu_matrix_buffer_if bus_if();

  tpu_matrix_buffer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] ma [64];
  logic [15:0] mb [64];
  logic [15:0] mr [64];
  int          clr_left;
  int          cnt;
  logic [15:0] e_a, e_b;
  bit          e_valid, e_blk, e_par, mem_known;

  typedef struct {
    logic [1:0] sel;
    bit         we;
    bit         ca;
    bit         res_we;
    bit         exp_blk;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.host_addr      = '0;
    bus_if.host_wdata     = '0;
    bus_if.host_we        = 1'b0;
    bus_if.host_sel       = SEL_NONE;
    bus_if.compute_active = 1'b0;
    bus_if.clear_req      = 1'b0;
    bus_if.cmp_a_addr     = '0;
    bus_if.cmp_b_addr     = '0;
    bus_if.cmp_rd_en      = 1'b0;
    bus_if.cmp_res_we     = 1'b0;
    bus_if.cmp_res_addr   = '0;
    bus_if.cmp_res_wdata  = '0;
  endtask

  function automatic logic [15:0] model_host_read(input logic [1:0] sel, input logic [7:0] addr);
    int unsigned i;
    i = int'(addr) % 64;
    case (sel)
      2'b00:   return ma[i];
      2'b01:   return mb[i];
      2'b10:   return mr[i];
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    clr_left = 64;
    cnt      = 0;
    e_a      = '0;
    e_b      = '0;
    e_valid  = 1'b0;
    e_blk    = 1'b0;
    e_par    = 1'b0;
  endtask

  // One clock: check the async read, advance the model on the current inputs, check registered outputs.
  task automatic cycle();
    bit clearing;
    int unsigned idx, ha;
    logic [1:0] sel;
    #1;
    sel = bus_if.host_sel;
    if (mem_known)
      chk("host_rdata", bus_if.host_rdata, model_host_read(sel, bus_if.host_addr));

    clearing = (clr_left > 0);
    ha       = int'(bus_if.host_addr) % 64;
    if (bus_if.cmp_rd_en) begin
      e_a = ma[bus_if.cmp_a_addr];
      e_b = mb[bus_if.cmp_b_addr];
    end
    e_valid = bus_if.cmp_rd_en;
    e_blk   = bus_if.host_we && sel != 2'b11 &&
              (clearing || (bus_if.compute_active && sel < 2'b10) ||
               (sel == 2'b10 && bus_if.cmp_res_we));
    if (clearing) begin
      idx = 64 - clr_left;
      ma[idx] = '0; mb[idx] = '0; mr[idx] = '0;
      clr_left--;
      if (clr_left == 0) begin
        cnt       = 0;
        e_par     = 1'b0;
        mem_known = 1'b1;
      end else if (e_blk && cnt < 255) cnt++;
    end else begin
      if (bus_if.cmp_res_we) mr[bus_if.cmp_res_addr] = bus_if.cmp_res_wdata;
      if (bus_if.host_we && !e_blk) begin
        if (sel == 2'b00) ma[ha] = bus_if.host_wdata;
        if (sel == 2'b01) mb[ha] = bus_if.host_wdata;
        if (sel == 2'b10) mr[ha] = bus_if.host_wdata;
      end
      if (e_blk && cnt < 255) cnt++;
      if (bus_if.clear_req) clr_left = 64;
    end

    @(posedge clk);
    #1;
    chk("cmp_rd_valid", bus_if.cmp_rd_valid, e_valid);
    chk("cmp_a_rdata", bus_if.cmp_a_rdata, e_a);
    chk("cmp_b_rdata", bus_if.cmp_b_rdata, e_b);
    chk("host_wr_blocked", bus_if.host_wr_blocked, e_blk);
    chk("blocked_cnt", bus_if.blocked_cnt, cnt);
    chk("clear_busy", bus_if.clear_busy, clr_left > 0);
    chk("par_err", bus_if.par_err, e_par);
  endtask

  task automatic count_clear(input int start_pulse_at, output int n);
    n = 0;
    while (bus_if.clear_busy && n < 200) begin
      bus_if.clear_req = (n == start_pulse_at);
      cycle();
      n++;
    end
    bus_if.clear_req = 1'b0;
  endtask

  initial begin
    vec_t vecs [12];
    int   n;

    for (int unsigned i = 0; i < 64; i++) begin
      ma[i] = '0; mb[i] = '0; mr[i] = '0;
    end
    mem_known = 1'b0;
    idle_inputs();

    // reset state
    rst = 1'b1;
    model_reset();
    #23;
    chk("rst clear_busy", bus_if.clear_busy, 1);
    chk("rst blocked_cnt", bus_if.blocked_cnt, 0);
    chk("rst cmp_rd_valid", bus_if.cmp_rd_valid, 0);
    chk("rst cmp_a_rdata", bus_if.cmp_a_rdata, 0);
    chk("rst host_wr_blocked", bus_if.host_wr_blocked, 0);
    chk("rst par_err", bus_if.par_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // the release edge already performed the first zero-fill write
    clr_left = 63;
    count_clear(-1, n);
    chk("initial clear length", n + 1, 64);

    bus_if.host_sel = SEL_A;    bus_if.host_addr = 8'd0;  #1;
    chk("A[0] after clear", bus_if.host_rdata, 16'h0000);
    bus_if.host_sel = SEL_B;    bus_if.host_addr = 8'd63; #1;
    chk("B[63] after clear", bus_if.host_rdata, 16'h0000);
    bus_if.host_sel = SEL_RES;  bus_if.host_addr = 8'd17; #1;
    chk("R[17] after clear", bus_if.host_rdata, 16'h0000);

    // host write then async + registered read
    idle_inputs();
    bus_if.host_sel = SEL_A; bus_if.host_addr = 8'd5; bus_if.host_wdata = 16'h3C00; bus_if.host_we = 1'b1;
    cycle();
    bus_if.host_we = 1'b0; bus_if.cmp_a_addr = 6'd5; bus_if.cmp_rd_en = 1'b1;
    #1;
    chk("A[5] async read", bus_if.host_rdata, 16'h3C00);
    cycle();
    chk("A[5] compute read", bus_if.cmp_a_rdata, 16'h3C00);
    chk("A[5] rd_valid", bus_if.cmp_rd_valid, 1);

    // operand lock
    idle_inputs();
    bus_if.compute_active = 1'b1;
    bus_if.host_sel = SEL_B; bus_if.host_addr = 8'd2; bus_if.host_wdata = 16'h4000; bus_if.host_we = 1'b1;
    cycle();
    chk("lock blocked pulse", bus_if.host_wr_blocked, 1);
    chk("lock blocked_cnt", bus_if.blocked_cnt, 1);
    idle_inputs();
    bus_if.host_sel = SEL_B; bus_if.host_addr = 8'd2; #1;
    chk("B[2] unchanged", bus_if.host_rdata, 16'h0000);

    // compute wins result-bank conflict
    idle_inputs();
    bus_if.cmp_res_we = 1'b1; bus_if.cmp_res_addr = 6'd9; bus_if.cmp_res_wdata = 16'h1234;
    bus_if.host_sel = SEL_RES; bus_if.host_addr = 8'd9; bus_if.host_wdata = 16'hFFFF; bus_if.host_we = 1'b1;
    cycle();
    chk("res conflict blocked", bus_if.host_wr_blocked, 1);
    idle_inputs();
    bus_if.host_sel = SEL_RES; bus_if.host_addr = 8'd9; #1;
    chk("R[9] compute value", bus_if.host_rdata, 16'h1234);

    // blocking rules table
    vecs[0]  = '{2'b00, 1, 0, 0, 0};
    vecs[1]  = '{2'b01, 1, 0, 0, 0};
    vecs[2]  = '{2'b10, 1, 0, 0, 0};
    vecs[3]  = '{2'b11, 1, 0, 0, 0};
    vecs[4]  = '{2'b00, 1, 1, 0, 1};
    vecs[5]  = '{2'b01, 1, 1, 0, 1};
    vecs[6]  = '{2'b10, 1, 1, 0, 0};
    vecs[7]  = '{2'b11, 1, 1, 0, 0};
    vecs[8]  = '{2'b10, 1, 0, 1, 1};
    vecs[9]  = '{2'b00, 1, 0, 1, 0};
    vecs[10] = '{2'b00, 0, 1, 0, 0};
    vecs[11] = '{2'b11, 1, 1, 1, 0};
    for (int unsigned i = 0; i < 12; i++) begin
      idle_inputs();
      bus_if.host_sel       = vecs[i].sel;
      bus_if.host_we        = vecs[i].we;
      bus_if.compute_active = vecs[i].ca;
      bus_if.cmp_res_we     = vecs[i].res_we;
      bus_if.host_addr      = 8'($urandom);
      bus_if.host_wdata     = 16'($urandom);
      bus_if.cmp_res_addr   = 6'($urandom);
      bus_if.cmp_res_wdata  = 16'($urandom);
      cycle();
      chk($sformatf("table[%0d] blocked", i), bus_if.host_wr_blocked, vecs[i].exp_blk);
    end

    // saturation, then clear with an ignored mid-clear request
    idle_inputs();
    bus_if.compute_active = 1'b1; bus_if.host_sel = SEL_A; bus_if.host_we = 1'b1;
    for (int unsigned i = 0; i < 300; i++) cycle();
    chk("blocked_cnt saturated", bus_if.blocked_cnt, 255);
    idle_inputs();
    bus_if.clear_req = 1'b1;
    cycle();
    bus_if.clear_req = 1'b0;
    count_clear(10, n);
    chk("clear length with mid req", n, 64);
    chk("blocked_cnt after clear", bus_if.blocked_cnt, 0);

    // randomized traffic against the model
    for (int unsigned i = 0; i < 600; i++) begin
      bus_if.host_sel       = 2'($urandom_range(0, 3));
      bus_if.host_addr      = 8'($urandom);
      bus_if.host_wdata     = 16'($urandom);
      bus_if.host_we        = 1'($urandom_range(0, 1));
      bus_if.compute_active = ($urandom_range(0, 3) == 0);
      bus_if.clear_req      = ($urandom_range(0, 149) == 0);
      bus_if.cmp_a_addr     = 6'($urandom);
      bus_if.cmp_b_addr     = 6'($urandom);
      bus_if.cmp_rd_en      = 1'($urandom_range(0, 1));
      bus_if.cmp_res_we     = ($urandom_range(0, 2) == 0);
      bus_if.cmp_res_addr   = 6'($urandom);
      bus_if.cmp_res_wdata  = 16'($urandom);
      cycle();
    end
    idle_inputs();
    n = 0;
    while (bus_if.clear_busy && n < 200) begin cycle(); n++; end
    chk("random settle", bus_if.clear_busy, 0);

`ifdef MEM_PARITY_EN
    idle_inputs();
    bus_if.host_sel = SEL_A; bus_if.host_addr = 8'd3; bus_if.host_wdata = 16'h00A5; bus_if.host_we = 1'b1;
    cycle();
    idle_inputs();
    dut.u_bank_a.mem[3][16] = ~dut.u_bank_a.mem[3][16];
    bus_if.cmp_a_addr = 6'd3; bus_if.cmp_rd_en = 1'b1;
    e_par = 1'b1;
    cycle();
    chk("par_err set", bus_if.par_err, 1);
    idle_inputs();
    for (int unsigned i = 0; i < 5; i++) cycle();
    chk("par_err sticky", bus_if.par_err, 1);
    bus_if.clear_req = 1'b1;
    cycle();
    bus_if.clear_req = 1'b0;
    count_clear(-1, n);
    chk("par_err cleared", bus_if.par_err, 0);
`endif

    // reset in the middle of a clear restarts it from address 0
    idle_inputs();
    bus_if.clear_req = 1'b1;
    cycle();
    bus_if.clear_req = 1'b0;
    for (int unsigned i = 0; i < 20; i++) cycle();
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid rst clear_busy", bus_if.clear_busy, 1);
    chk("mid rst rd_valid", bus_if.cmp_rd_valid, 0);
    #1;
    rst = 1'b0;
    count_clear(-1, n);
    chk("clear length after mid rst", n, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
